period_to_bpm: RTL and testbench
================================

Name: period_to_bpm

Overview:
- Converts a measured button-tap period, counted in timepulse units, into beats-per-minute for the tap-tempo display path.
- Sits between the period counter, which drives btn_per_i/btn_per_valid, and the BPM display/PWM stage, which consumes bpm_o/bpm_valid.
- Uses a multi-cycle sequential divider with saturation at BPM_MAX.

Parameters:
- TP_CYCLE, 5120: clock cycles per timepulse (25 MHz clock, 40 ns period).
- MIN_US, 60_000_000: microseconds per minute.
- BPM_MAX, 250: saturation value of bpm_o.
- PER_WIDTH, 24: width of btn_per_i.
- BPM_WIDTH, 8: width of bpm_o.
- Derived constants, not overridable:
  - DIVIDEND = 1000*(MIN_US/TP_CYCLE) = 11_718_000, using integer division (MIN_US/TP_CYCLE = 11718).
  - PER_MIN = DIVIDEND/BPM_MAX = 46_872.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- btn_per_i  in  PER_WIDTH  tap period in timepulses.
- btn_per_valid  in  1  btn_per_i valid this cycle.
- bpm_o  out  BPM_WIDTH  computed BPM.
- bpm_valid  out  1  one-cycle pulse; bpm_o carries a new result.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: rst_ni low at a rising edge resets all state.
  - Reset values: bpm_valid=0, bpm_o=0, FSM=IDLE, internal registers=0.
  - Reset mid-computation aborts it; no bpm_valid is produced for the aborted request.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - When btn_per_valid=1 at an edge, latch the divisor = max(btn_per_i, PER_MIN) and go to DIV.
  - A period of 0, or any value below 46_872, is clamped to 46_872.
- DIV:
  - 8-iteration restoring division of DIVIDEND by the latched divisor, one quotient bit per cycle, MSB first.
  - 8 bits suffice because divisor*256 > DIVIDEND whenever divisor >= PER_MIN.
  - After 8 iterations, go to DONE.
- DONE:
  - Register bpm_o = min(quotient, BPM_MAX), pulse bpm_valid=1 for exactly one cycle, return to IDLE.
- Result: bpm_o = min(floor(11_718_000 / max(per, 46_872)), 250). Result is always <= 250; it is 0 for per > 11_718_000.
- Latency:
  - Request accepted at edge k; bpm_valid is high during the cycle after edge k+9.
  - Exactly one result per accepted request.
- Handshake:
  - No backpressure.
  - btn_per_valid while in DIV or DONE is ignored and dropped.
  - A new request is accepted in the same cycle the FSM returns to IDLE, i.e. the cycle bpm_valid is high.
- Output hold: bpm_o holds its last result between computations and changes only together with bpm_valid.
- bpm_valid is never high while rst_ni is low, nor in the cycle immediately after reset is released.

Optional Feature:
- Macro: PER2BPM_BUSY_EN.
- With the macro defined:
  - Adds output port busy_o (1 bit).
  - busy_o is high while in DIV or DONE and low in IDLE; its reset value is 0.
  - An upstream stage can use it to avoid dropped requests.
- Without the macro:
  - The port is absent.
  - Requests arriving while busy are silently dropped; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles with btn_per_valid=0 -> bpm_valid=0, bpm_o=0 throughout and one cycle after release.
- btn_per_i=117_180, valid 1 cycle -> bpm_valid pulse 9 cycles later with bpm_o=100. Also btn_per_i=58_590 -> bpm_o=200.
- Clamp/saturation: btn_per_i=0, 100, and 46_872 each -> bpm_o=250; btn_per_i=46_873 -> bpm_o=249.
- Low end: btn_per_i=11_718_000 -> 1; btn_per_i=16_777_215 -> 0.
- Busy drop: send 117_180, then 58_590 two cycles later -> exactly one result (100). A second request issued in the bpm_valid cycle is accepted and yields its result 9 cycles later.
- Reset asserted 4 cycles into a computation -> no bpm_valid pulse, bpm_o=0. A following request computes correctly.

Source files
------------

// File: rtl/period_to_bpm.sv
// Tap period (timepulses) to BPM via an 8-step restoring divider, saturating at BPM_MAX.
// Define PER2BPM_BUSY_EN to add busy_o (high while a division is in flight).
module period_to_bpm #(
  parameter int TP_CYCLE  = 5120,
  parameter int MIN_US    = 60_000_000,
  parameter int BPM_MAX   = 250,
  parameter int PER_WIDTH = 24,
  parameter int BPM_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [PER_WIDTH-1:0] btn_per_i,
  input  logic                 btn_per_valid,
  output logic [BPM_WIDTH-1:0] bpm_o,
  output logic                 bpm_valid
`ifdef PER2BPM_BUSY_EN
  ,
  output logic                 busy_o
`endif
);

  localparam int DIVIDEND = 1000 * (MIN_US / TP_CYCLE);
  localparam int PER_MIN  = DIVIDEND / BPM_MAX;
  localparam int QW       = 8;
  localparam int DW       = PER_WIDTH + QW;

  localparam logic [PER_WIDTH-1:0] PER_MIN_V  = PER_WIDTH'(PER_MIN);
  localparam logic [DW-1:0]        DIVIDEND_V = DW'(DIVIDEND);
  localparam logic [QW-1:0]        BPM_MAX_Q  = QW'(BPM_MAX);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t              state;
  logic [DW-1:0]       rem;
  logic [DW-1:0]       dsh;
  logic [QW-1:0]       quo;
  logic [2:0]          cnt;
  logic [PER_WIDTH-1:0] per_clamped;
  logic                busy;

  assign per_clamped = (btn_per_i < PER_MIN_V) ? PER_MIN_V : btn_per_i;
  assign busy        = (state != IDLE);

  // dsh starts at divisor<<7 and walks right, so each DIV cycle decides one
  // quotient bit MSB first; the clamp guarantees the quotient fits in 8 bits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rem       <= '0;
      dsh       <= '0;
      quo       <= '0;
      cnt       <= '0;
      bpm_o     <= '0;
      bpm_valid <= 1'b0;
    end else begin
      bpm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_per_valid) begin
            rem   <= DIVIDEND_V;
            dsh   <= DW'(per_clamped) << (QW - 1);
            quo   <= '0;
            cnt   <= 3'd7;
            state <= DIV;
          end
        end
        DIV: begin
          if (rem >= dsh) begin
            rem <= rem - dsh;
            quo <= {quo[QW-2:0], 1'b1};
          end else begin
            quo <= {quo[QW-2:0], 1'b0};
          end
          dsh <= dsh >> 1;
          if (cnt == 3'd0) state <= DONE;
          else             cnt   <= cnt - 3'd1;
        end
        DONE: begin
          bpm_o     <= (quo > BPM_MAX_Q) ? BPM_WIDTH'(BPM_MAX_Q) : BPM_WIDTH'(quo);
          bpm_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PER2BPM_BUSY_EN
  assign busy_o = busy;
`else
  logic unused_busy;
  assign unused_busy = busy;
`endif

endmodule

// File: tb/tb_period_to_bpm.sv
// Scoreboard bench for period_to_bpm: expected BPM and due cycle queued at drive time.
module tb_period_to_bpm;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [23:0] btn_per_i;
  logic        btn_per_valid;
  logic [7:0]  bpm_o;
  logic        bpm_valid;
`ifdef PER2BPM_BUSY_EN
  logic        busy_o;
`endif

  period_to_bpm dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .btn_per_i     (btn_per_i),
    .btn_per_valid (btn_per_valid),
    .bpm_o         (bpm_o),
    .bpm_valid     (bpm_valid)
`ifdef PER2BPM_BUSY_EN
    ,
    .busy_o        (busy_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int exp; int due; } sb_t;
  sb_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model(input longint per);
    longint d, q;
    d = (per < 46872) ? 46872 : per;
    q = 11718000 / d;
    if (q > 250) q = 250;
    return int'(q);
  endfunction

  // Monitor: every bpm_valid must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bpm_valid) begin
      if (sbq.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        sb_t e;
        e = sbq.pop_front();
        chk("latency", cyc, e.due);
        chk("bpm", int'(bpm_o), e.exp);
      end
    end
  end

  task automatic send(input int per, input bit expect_acc);
    @(negedge clk);
    btn_per_i     = 24'(per);
    btn_per_valid = 1'b1;
    if (expect_acc) begin
      sbq.push_back('{exp: model(longint'(per)), due: cyc + 10});
      last = model(longint'(per));
    end
    @(negedge clk);
    btn_per_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin
    int n;
    rst_ni        = 1'b0;
    btn_per_i     = '0;
    btn_per_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", int'(bpm_valid), 0);
      chk("rst_bpm", int'(bpm_o), 0);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", int'(bpm_valid), 0);
    chk("post_rst_bpm", int'(bpm_o), 0);

    // main function, clamp, saturation and low end
    send(117_180, 1'b1);   drain();
    send(58_590, 1'b1);    drain();
    send(0, 1'b1);         drain();
    send(100, 1'b1);       drain();
    send(46_872, 1'b1);    drain();
    send(46_873, 1'b1);    drain();
    send(11_718_000, 1'b1); drain();
    send(16_777_215, 1'b1); drain();
    repeat (5) @(negedge clk);
    chk("hold", int'(bpm_o), last);
    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(46_000, 600_000)), 1'b1);
      drain();
    end
    send(int'($urandom_range(0, 24'hFF_FFFF)), 1'b1); drain();

    // request during DIV is dropped
    send(117_180, 1'b1);
    @(negedge clk);
    send(58_590, 1'b0);
    drain();
    repeat (12) @(negedge clk);
    chk("drop_bpm", int'(bpm_o), 100);

    // request issued in the bpm_valid cycle is accepted
    send(117_180, 1'b1);
    n = 0;
    while (!bpm_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("saw_valid", int'(bpm_valid), 1);
    btn_per_i     = 24'd58_590;
    btn_per_valid = 1'b1;
    sbq.push_back('{exp: 200, due: cyc + 10});
    @(negedge clk);
    btn_per_valid = 1'b0;
    drain();

    // reset mid-computation aborts without a result
    send(117_180, 1'b0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(bpm_valid), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (14) @(negedge clk);
    chk("abort_bpm", int'(bpm_o), 0);
    send(58_590, 1'b1);
    drain();
    chk("after_abort_bpm", int'(bpm_o), 200);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
